// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the Lab7 multicycle MIPS control unit: state names,
// opcodes and the datapath mux select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode: maps the current state (plus mem_ready, which only
// qualifies the FETCH strobes) onto every datapath control line.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PC_ALU;
        illegal       = 1'b0;
        case (state)
            // IR and PC load once, in the cycle the instruction word arrives
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SHL2;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_JUMP;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_TRAP:   illegal   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: state register and next-state sequencing;
// the control outputs come from the mips_ctrl_decode instance.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_n;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_n;
    end

    // Unreachable encodings fall through the default and recover to FETCH
    always_comb begin
        state_n = S_FETCH;
        case (state_q)
            S_FETCH:  state_n = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_n = S_EXEC;
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_BEQ:       state_n = S_BRANCH;
                    OP_J:         state_n = S_JUMP;
                    OP_ADDI:      state_n = S_ADDIEX;
                    default:      state_n = S_TRAP;
                endcase
            end
            S_MEMADR: state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_n = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_n = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_n = S_RWB;
            S_ADDIEX: state_n = S_ADDIWB;
            S_TRAP:   state_n = S_TRAP;
            default:  state_n = S_FETCH;
        endcase
    end

    assign state = state_q;

    mips_ctrl_decode u_decode (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal       (illegal)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: an instruction-path model checked every
// cycle, plus directed instruction sequences with literal expectations.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'b100011;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal       (illegal),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Instruction path after DECODE, as a list of states; -1 ends the path
    function automatic int routeState(input logic [5:0] op, input int k);
        int r[3];
        r = '{-1, -1, -1};
        case (op)
            LW:      r = '{2, 3, 4};
            SW:      r = '{2, 5, -1};
            RT:      r = '{6, 7, -1};
            BEQ:     r = '{8, -1, -1};
            JMP:     r = '{9, -1, -1};
            ADDI:    r = '{10, 11, -1};
            default: r = '{12, -1, -1};
        endcase
        return (k < 3) ? r[k] : -1;
    endfunction

    function automatic logic [16:0] expCtrl(input int s, input logic rdy);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rwr = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rwr = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin pcw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rwr = 1;
            12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, psrc, ill};
    endfunction

    int         mState = 0;
    int         mPos = 0;
    logic [5:0] mOp = '0;
    bit         mValid = 0;

    always @(posedge clk) begin
        if (reset) begin
            mState <= 0;
            mPos   <= 0;
            mValid <= 1;
        end else if (mValid) begin
            if (mState == 12) begin
                mState <= 12;
            end else if ((mState == 0 || mState == 3 || mState == 5) && !mem_ready) begin
                mState <= mState;
            end else if (mState == 0) begin
                mState <= 1;
            end else if (mState == 1) begin
                mOp    <= opcode;
                mState <= routeState(opcode, 0);
                mPos   <= 1;
            end else begin
                mState <= (routeState(mOp, mPos) < 0) ? 0 : routeState(mOp, mPos);
                mPos   <= mPos + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("model_state", int'(state), mState);
            checkOutput("model_ctrl",
                int'({pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal}),
                int'(expCtrl(mState, mem_ready)));
        end
    end

    logic snapMemWrite, snapIorD, snapIrWrite, snapPcWrite, snapPcWriteCond;
    logic snapRegWrite, snapMemToReg, snapIllegal;
    logic [1:0] snapPcSource;

    // Drive one cycle of inputs, snapshot outputs mid-cycle, then check the state it lands in
    task automatic applyStimulus(input logic r, input logic [5:0] op, input logic rdy, input int expState);
        reset = r; opcode = op; mem_ready = rdy;
        @(negedge clk);
        snapMemWrite = mem_write; snapIorD = i_or_d; snapIrWrite = ir_write;
        snapPcWrite = pc_write; snapPcWriteCond = pc_write_cond; snapRegWrite = reg_write;
        snapMemToReg = mem_to_reg; snapIllegal = illegal; snapPcSource = pc_source;
        @(posedge clk);
        #1;
        checkOutput("next_state", int'(state), expState);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cntA, cntB, cntC;
        #1;
        applyStimulus(1, LW, 1, 0);
        applyStimulus(1, LW, 1, 0);
        checkOutput("rst_mem_read", int'(mem_read), 1);
        checkOutput("rst_alu_src_b", int'(alu_src_b), 1);
        checkOutput("rst_illegal", int'(illegal), 0);
        checkOutput("rst_ir_write", int'(ir_write), 1);

        applyStimulus(0, LW, 1, 1);
        applyStimulus(0, LW, 1, 2);
        applyStimulus(0, LW, 1, 3);
        applyStimulus(0, LW, 1, 4);
        applyStimulus(0, LW, 1, 0);
        checkOutput("lw_wb_reg_write", int'(snapRegWrite & snapMemToReg), 1);

        cntA = 0; cntB = 0;
        applyStimulus(0, SW, 1, 1);
        applyStimulus(0, SW, 1, 2);
        cntB += int'(snapRegWrite);
        applyStimulus(0, SW, 0, 5);
        cntA += int'(snapMemWrite & snapIorD); cntB += int'(snapRegWrite);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, SW, 0, 5);
            cntA += int'(snapMemWrite & snapIorD); cntB += int'(snapRegWrite);
        end
        applyStimulus(0, SW, 1, 0);
        cntA += int'(snapMemWrite & snapIorD); cntB += int'(snapRegWrite);
        checkOutput("sw_write_cycles", cntA, 4);
        checkOutput("sw_reg_write", cntB, 0);

        cntA = 0; cntB = 0;
        applyStimulus(0, RT, 0, 0);
        cntA += int'(snapIrWrite); cntB += int'(snapPcWrite);
        applyStimulus(0, RT, 0, 0);
        cntA += int'(snapIrWrite); cntB += int'(snapPcWrite);
        applyStimulus(0, RT, 1, 1);
        cntA += int'(snapIrWrite); cntB += int'(snapPcWrite);
        checkOutput("fetch_ir_write_count", cntA, 1);
        checkOutput("fetch_pc_write_count", cntB, 1);

        cntA = 0; cntB = 0; cntC = 0;
        applyStimulus(0, RT, 1, 6);
        applyStimulus(0, RT, 1, 7);
        cntA += int'(snapPcWriteCond); cntB += int'(snapPcSource == 2'b10);
        applyStimulus(0, RT, 1, 0);
        cntA += int'(snapPcWriteCond); cntB += int'(snapPcSource == 2'b10);
        applyStimulus(0, BEQ, 1, 1);
        applyStimulus(0, BEQ, 1, 8);
        cntA += int'(snapPcWriteCond); cntB += int'(snapPcSource == 2'b10);
        applyStimulus(0, BEQ, 1, 0);
        cntA += int'(snapPcWriteCond); cntB += int'(snapPcSource == 2'b10);
        cntC = int'(snapPcWriteCond);
        applyStimulus(0, JMP, 1, 1);
        applyStimulus(0, JMP, 1, 9);
        cntA += int'(snapPcWriteCond); cntB += int'(snapPcSource == 2'b10);
        applyStimulus(0, JMP, 1, 0);
        cntA += int'(snapPcWriteCond); cntB += int'(snapPcSource == 2'b10);
        checkOutput("beq_pc_write_cond", cntC, 1);
        checkOutput("pc_write_cond_count", cntA, 1);
        checkOutput("jump_pc_source_count", cntB, 1);

        applyStimulus(0, ADDI, 1, 1);
        applyStimulus(0, ADDI, 1, 10);
        applyStimulus(0, ADDI, 1, 11);
        applyStimulus(0, ADDI, 1, 0);
        checkOutput("addi_wb_reg_write", int'(snapRegWrite), 1);

        applyStimulus(0, BAD, 1, 1);
        applyStimulus(0, BAD, 1, 12);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 6'($urandom), 1'($urandom), 12);
            checkOutput("trap_illegal", int'(snapIllegal), 1);
        end
        applyStimulus(1, BAD, 0, 0);
        checkOutput("trap_reset_illegal", int'(illegal), 0);

        applyStimulus(0, LW, 1, 1);
        applyStimulus(0, LW, 1, 2);
        applyStimulus(0, LW, 0, 3);
        applyStimulus(0, LW, 0, 3);
        applyStimulus(1, LW, 0, 0);

        applyStimulus(0, SW, 1, 1);
        applyStimulus(0, SW, 1, 2);
        applyStimulus(0, SW, 0, 5);
        applyStimulus(1, SW, 0, 0);
        applyStimulus(0, SW, 0, 0);
        checkOutput("abandon_mem_write", int'(snapMemWrite), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
